// File: rtl/prio_mux_reg.sv
// Registered N-channel priority multiplexer with valid/ready on both sides.
// Define PRIO_MUX_RR_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module prio_mux_reg #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [N-1:0]   out_sel,
    output logic [IW-1:0]  out_idx,
    input  logic           out_ready
);

    logic          any;
    logic          accept;
    logic          xfer;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [N-1:0]  win_oh;
    logic [W-1:0]  win_data;
    logic [2*N-1:0] rot;

    assign any    = |in_valid;
    assign accept = !out_valid || out_ready;
    assign xfer   = accept && any && !rst;

`ifdef PRIO_MUX_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (xfer)
            ptr <= (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end
`else
    assign ptr = '0;
`endif

    // Rotate requests so the search always starts at ptr; fixed mode is ptr == 0.
    assign rot = {in_valid, in_valid} >> ptr;

    always_comb begin
        int  sum;
        logic found;
        win   = '0;
        found = 1'b0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= N)
                    sum = sum - N;
                win = IW'(sum);
            end
        end
    end

    assign win_oh   = N'(1) << win;
    assign win_data = W'(in_data >> (int'(win) * W));
    assign in_ready = xfer ? win_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_idx   <= '0;
        end else if (accept) begin
            // An idle load clears the stage so no stale item is ever visible.
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= win_oh;
                out_idx   <= win;
            end else begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_sel   <= '0;
                out_idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_mux_reg.sv
// Directed bench for prio_mux_reg (N=4, W=8); expectations follow PRIO_MUX_RR_EN when defined.
module tb_prio_mux_reg;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [N-1:0]   out_sel;
    logic [1:0]     out_idx;
    logic           out_ready;

    int total  = 0;
    int passed = 0;

    prio_mux_reg #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_idx(out_idx), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  iv;
        logic [31:0] d;
        logic        ord;
        logic [3:0]  ir;
        logic        ov;
        logic [7:0]  od;
        logic [3:0]  sel;
        logic [1:0]  idx;
        string       nm;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input logic ov, input logic [7:0] od,
                           input logic [3:0] sel, input logic [1:0] idx);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, ".out_data"},  32'(out_data),  32'(od));
        chk({nm, ".out_sel"},   32'(out_sel),   32'(sel));
        chk({nm, ".out_idx"},   32'(out_idx),   32'(idx));
    endtask

    // Drive one cycle: check the combinational grant, then let the edge happen.
    task automatic step(input string nm, input logic [3:0] iv, input logic [31:0] d,
                        input logic ord, input logic [3:0] ir);
        in_valid  = iv;
        in_data   = d;
        out_ready = ord;
        #1;
        chk({nm, ".in_ready"}, 32'(in_ready), 32'(ir));
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ALL = 32'hD3C2B1A0;

`ifdef PRIO_MUX_RR_EN
    int rr_exp[6]  = '{0, 1, 2, 3, 0, 1};
    int wrap_exp[2] = '{2, 0};
    int mid_exp[2]  = '{1, 2};
`else
    int rr_exp[6]  = '{0, 0, 0, 0, 0, 0};
    int wrap_exp[2] = '{0, 0};
    int mid_exp[2]  = '{0, 0};
`endif

    task automatic all_grant(input string nm, input logic [3:0] iv, input int idx);
        logic [7:0] d;
        d = 8'hA0 + 8'(8'h11 * idx);
        step(nm, iv, ALL, 1'b1, 4'(1 << idx));
        chk_out(nm, 1'b1, d, 4'(1 << idx), 2'(idx));
    endtask

    initial begin
        tbl[0]  = '{4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, "idle"};
        tbl[1]  = '{4'b1010, 32'h33001100, 1'b1, 4'b0010, 1'b1, 8'h11, 4'b0010, 2'd1, "prio"};
        tbl[2]  = '{4'b0001, 32'h00000055, 1'b0, 4'b0000, 1'b1, 8'h11, 4'b0010, 2'd1, "bp0"};
        tbl[3]  = '{4'b0001, 32'h00000055, 1'b0, 4'b0000, 1'b1, 8'h11, 4'b0010, 2'd1, "bp1"};
        tbl[4]  = '{4'b0001, 32'h00000055, 1'b0, 4'b0000, 1'b1, 8'h11, 4'b0010, 2'd1, "bp2"};
        tbl[5]  = '{4'b0001, 32'h00000055, 1'b1, 4'b0001, 1'b1, 8'h55, 4'b0001, 2'd0, "bp_rel"};
        tbl[6]  = '{4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, "clear"};
        tbl[7]  = '{4'b1000, 32'h33000000, 1'b0, 4'b1000, 1'b1, 8'h33, 4'b1000, 2'd3, "empty_ld"};
        tbl[8]  = '{4'b1100, 32'h33220000, 1'b1, 4'b0100, 1'b1, 8'h22, 4'b0100, 2'd2, "poppush"};
        tbl[9]  = '{4'b0011, 32'h0000A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001, 2'd0, "lo2"};
        tbl[10] = '{4'b0000, 32'h0,        1'b0, 4'b0000, 1'b1, 8'hA0, 4'b0001, 2'd0, "hold"};
        tbl[11] = '{4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, "clear2"};

        // Reset for two cycles with every channel requesting.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step($sformatf("rst%0d", i), 4'b1111, ALL, 1'b1, 4'b0000);
            chk_out($sformatf("rst%0d", i), 1'b0, 8'h00, 4'b0000, 2'd0);
        end
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].nm, tbl[i].iv, tbl[i].d, tbl[i].ord, tbl[i].ir);
            chk_out(tbl[i].nm, tbl[i].ov, tbl[i].od, tbl[i].sel, tbl[i].idx);
        end

        // Clean pointer, then continuous requests on all channels.
        rst = 1'b1;
        step("rst_b", 4'b0000, 32'h0, 1'b1, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 6; i++)
            all_grant($sformatf("seq%0d", i), 4'b1111, rr_exp[i]);

        // Only ch2 and ch0 request: wrap from ch2 back to ch0.
        for (int i = 0; i < 2; i++)
            all_grant($sformatf("wrap%0d", i), 4'b0101, wrap_exp[i]);

        for (int i = 0; i < 2; i++)
            all_grant($sformatf("mid%0d", i), 4'b1111, mid_exp[i]);

        // Reset mid-stream discards the held item and blocks the transfer.
        rst = 1'b1;
        step("rst_mid", 4'b1111, ALL, 1'b1, 4'b0000);
        chk_out("rst_mid", 1'b0, 8'h00, 4'b0000, 2'd0);
        rst = 1'b0;
        all_grant("post_rst", 4'b1111, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
